// File: rtl/tdc_delta_packer_pkg.sv
// -----------------------------------------------------------------------------
// tdc_pkg
// Shared definitions for the TDC delta packer:
//   - tdc_state_e : serializer FSM states (S_CHK only reachable when
//                   TDC_CHECKSUM_EN is defined)
//   - FRAME_HDR   : byte that opens every serialized frame
//   - tdc_delta_t : one counter delta, zero-extended to the 16-bit link width
//   - delta_byte  : picks the upper or lower byte of a zero-extended delta
// A frame of deltas is a packed array of CTR_NUMBER x DATA_W bits, declared
// in the top module from this delta type because its size follows the top's
// parameters.
// -----------------------------------------------------------------------------
package tdc_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_HI   = 3'd2,
        S_LO   = 3'd3,
        S_CHK  = 3'd4
    } tdc_state_e;

    localparam logic [7:0] FRAME_HDR   = 8'hA5;
    localparam int         DELTA_MAX_W = 16;

    typedef logic [DELTA_MAX_W-1:0] tdc_delta_t;

    // Upper byte when hi is set, lower byte otherwise.
    function automatic logic [7:0] delta_byte(input tdc_delta_t d, input logic hi);
        logic [7:0] b;
        if (hi) begin
            b = d[15:8];
        end else begin
            b = d[7:0];
        end
        return b;
    endfunction

endpackage

// File: rtl/tdc_frame_fifo.sv
// -----------------------------------------------------------------------------
// tdc_frame_fifo
// Single-clock synchronous FIFO holding whole delta frames.
// Pointers carry one extra bit so full and empty are told apart without a
// separate counter; level is the pointer difference.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   wr, wdata       write request and frame data (ignored when full unless
//                   a read happens in the same cycle)
//   rd, rdata       read request; rdata shows the head frame combinationally
//   full, empty     status
//   level           number of stored frames (0..DEPTH)
// -----------------------------------------------------------------------------
module tdc_frame_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     rd,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             wr_ok_s;
    logic             rd_ok_s;

    assign empty   = (wr_ptr_r == rd_ptr_r);
    assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign level   = wr_ptr_r - rd_ptr_r;
    assign rd_ok_s = rd && !empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign wr_ok_s = wr && (!full || rd_ok_s);
    assign rdata   = mem_r[rd_ptr_r[AW-1:0]];

    // Frame storage; contents need no reset because the pointers gate them.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        end
    end

    // Read and write pointers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (rd_ok_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/tdc_delta_packer.sv
// -----------------------------------------------------------------------------
// tdc_delta_packer
// Turns synchronized counter snapshots into per-counter deltas (modulo
// 2^DATA_W), queues delta frames in tdc_frame_fifo and serializes each frame
// as: 0xA5, then {hi, lo} byte per counter, optionally followed by an XOR
// checksum of all preceding frame bytes.
// Optional feature macro: TDC_CHECKSUM_EN (adds the S_CHK checksum byte).
// Ports:
//   clk          counter-0 domain clock
//   rst          asynchronous active-low reset
//   in_data      snapshot of CTR_NUMBER counters, DATA_W bits each
//   in_valid     one-cycle strobe qualifying in_data
//   out_byte     serialized byte (registered)
//   out_valid    out_byte valid (registered)
//   out_ready    sink accepts out_byte
//   overflow     sticky: a frame was dropped because the FIFO was full
//   fifo_level   frames currently stored in the FIFO
// -----------------------------------------------------------------------------
module tdc_delta_packer
    import tdc_pkg::*;
#(
    parameter int CTR_NUMBER = 1,
    parameter int DATA_W     = 10,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             in_data [CTR_NUMBER],
    input  logic                          in_valid,
    output logic [7:0]                    out_byte,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int FW = CTR_NUMBER * DATA_W;
    localparam int KW = (CTR_NUMBER > 1) ? $clog2(CTR_NUMBER) : 1;

    typedef logic [CTR_NUMBER-1:0][DATA_W-1:0] frame_t;

    logic [DATA_W-1:0] prev_r [CTR_NUMBER];
    logic              primed_r;
    frame_t            delta_s;
    frame_t            fifo_rdata_s;
    frame_t            frame_r;
    logic              push_s;
    logic              pop_s;
    logic              accept_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              xfer_s;
    logic              adv_s;
    tdc_state_e        state_r;
    tdc_state_e        state_next_s;
    logic [KW-1:0]     k_r;
    logic [KW-1:0]     k_next_s;
    logic [7:0]        out_byte_r;
    logic [7:0]        byte_next_s;
    logic              out_valid_r;
    logic              overflow_r;
    tdc_delta_t        sel_delta_s;
`ifdef TDC_CHECKSUM_EN
    logic [7:0]        chk_r;
`endif

    assign out_byte   = out_byte_r;
    assign out_valid  = out_valid_r;
    assign overflow   = overflow_r;

    // The first snapshot after reset only establishes the baseline.
    assign push_s   = in_valid && primed_r;
    assign pop_s    = (state_r == S_IDLE) && !fifo_empty_s;
    assign accept_s = push_s && (!fifo_full_s || pop_s);
    assign xfer_s   = out_valid_r && out_ready;
    // Output register may change only in IDLE or when the current byte leaves.
    assign adv_s    = (state_r == S_IDLE) || xfer_s;

    // Per-counter delta; DATA_W-wide subtraction drops the borrow, giving the wrap.
    always_comb begin
        delta_s = {FW{1'b0}};
        for (int i = 0; i < CTR_NUMBER; i++) begin
            delta_s[i] = in_data[i] - prev_r[i];
        end
    end

    // Baseline snapshot and primed flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            primed_r <= 1'b0;
            for (int i = 0; i < CTR_NUMBER; i++) begin
                prev_r[i] <= {DATA_W{1'b0}};
            end
        end else if (in_valid) begin
            primed_r <= 1'b1;
            for (int i = 0; i < CTR_NUMBER; i++) begin
                prev_r[i] <= in_data[i];
            end
        end
    end

    // Sticky drop flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_r <= 1'b0;
        end else if (push_s && !accept_s) begin
            overflow_r <= 1'b1;
        end
    end

    tdc_frame_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (accept_s),
        .wdata (delta_s),
        .rd    (pop_s),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (fifo_level)
    );

    // Serializer next state and counter index.
    always_comb begin
        state_next_s = state_r;
        k_next_s     = k_r;
        case (state_r)
            S_IDLE: begin
                k_next_s = {KW{1'b0}};
                if (!fifo_empty_s) begin
                    state_next_s = S_HDR;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_HDR: begin
                if (xfer_s) begin
                    state_next_s = S_HI;
                    k_next_s     = {KW{1'b0}};
                end else begin
                    state_next_s = S_HDR;
                end
            end
            S_HI: begin
                if (xfer_s) begin
                    state_next_s = S_LO;
                end else begin
                    state_next_s = S_HI;
                end
            end
            S_LO: begin
                if (xfer_s) begin
                    if (k_r == KW'(CTR_NUMBER - 1)) begin
`ifdef TDC_CHECKSUM_EN
                        state_next_s = S_CHK;
`else
                        state_next_s = S_IDLE;
`endif
                    end else begin
                        state_next_s = S_HI;
                        k_next_s     = k_r + KW'(1);
                    end
                end else begin
                    state_next_s = S_LO;
                end
            end
            S_CHK: begin
                if (xfer_s) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_CHK;
                end
            end
            default: begin
                state_next_s = S_IDLE;
                k_next_s     = {KW{1'b0}};
            end
        endcase
    end

    // Byte to present in the next state; held while the sink stalls.
    always_comb begin
        sel_delta_s                   = {DELTA_MAX_W{1'b0}};
        sel_delta_s[DATA_W-1:0]       = frame_r[k_next_s];
        byte_next_s                   = out_byte_r;
        if (adv_s) begin
            case (state_next_s)
                S_HDR:   byte_next_s = FRAME_HDR;
                S_HI:    byte_next_s = delta_byte(sel_delta_s, 1'b1);
                S_LO:    byte_next_s = delta_byte(sel_delta_s, 1'b0);
`ifdef TDC_CHECKSUM_EN
                // Entered as the last LO leaves, so fold that byte in here.
                S_CHK:   byte_next_s = chk_r ^ out_byte_r;
`endif
                default: byte_next_s = 8'h00;
            endcase
        end else begin
            byte_next_s = out_byte_r;
        end
    end

    // Serializer state, frame register and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= S_IDLE;
            k_r         <= {KW{1'b0}};
            frame_r     <= {FW{1'b0}};
            out_byte_r  <= 8'h00;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            k_r         <= k_next_s;
            out_byte_r  <= byte_next_s;
            out_valid_r <= (state_next_s != S_IDLE);
            if (pop_s) begin
                frame_r <= fifo_rdata_s;
            end
        end
    end

`ifdef TDC_CHECKSUM_EN
    // Running XOR of the bytes already sent in the current frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chk_r <= 8'h00;
        end else if (pop_s) begin
            chk_r <= 8'h00;
        end else if (xfer_s) begin
            chk_r <= chk_r ^ out_byte_r;
        end
    end
`endif

endmodule

// File: tb/tb_tdc_delta_packer.sv
// -----------------------------------------------------------------------------
// tb_tdc_delta_packer
// Self-checking bench for tdc_delta_packer. Two instances: CTR_NUMBER=1 and
// CTR_NUMBER=3 (both DATA_W=10, FIFO_DEPTH=16). Expected bytes are built from
// a reference delta model and queued when a sample is driven; a monitor per
// instance pops and compares on every accepted byte.
// -----------------------------------------------------------------------------
module tb_tdc_delta_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;

    logic [9:0] in_data1 [1];
    logic       in_valid1;
    logic [7:0] out_byte1;
    logic       out_valid1;
    logic       out_ready1;
    logic       overflow1;
    logic [4:0] fifo_level1;

    logic [9:0] in_data3 [3];
    logic       in_valid3;
    logic [7:0] out_byte3;
    logic       out_valid3;
    logic       out_ready3;
    logic       overflow3;
    logic [4:0] fifo_level3;

    tdc_delta_packer #(.CTR_NUMBER(1), .DATA_W(10), .FIFO_DEPTH(16)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data1),
        .in_valid   (in_valid1),
        .out_byte   (out_byte1),
        .out_valid  (out_valid1),
        .out_ready  (out_ready1),
        .overflow   (overflow1),
        .fifo_level (fifo_level1)
    );

    tdc_delta_packer #(.CTR_NUMBER(3), .DATA_W(10), .FIFO_DEPTH(16)) u_dut3 (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data3),
        .in_valid   (in_valid3),
        .out_byte   (out_byte3),
        .out_valid  (out_valid3),
        .out_ready  (out_ready3),
        .overflow   (overflow3),
        .fifo_level (fifo_level3)
    );

    int         tests_run    = 0;
    int         tests_failed = 0;
    logic [7:0] exp_q1 [$];
    logic [7:0] exp_q3 [$];
    logic [9:0] prev1;
    logic       primed1;
    logic [9:0] prev3 [3];
    logic       primed3;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Build the byte sequence of one frame and append it to an instance queue.
    task automatic push_frame(input int which, input int n,
                              input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2);
        logic [7:0]  b [$];
        logic [15:0] dv [3];
        logic [7:0]  x;
        dv = '{d0, d1, d2};
        b.push_back(8'hA5);
        for (int i = 0; i < n; i++) begin
            b.push_back(dv[i][15:8]);
            b.push_back(dv[i][7:0]);
        end
`ifdef TDC_CHECKSUM_EN
        x = 8'h00;
        foreach (b[i]) x = x ^ b[i];
        b.push_back(x);
`else
        x = 8'h00;
`endif
        foreach (b[i]) begin
            if (which == 1) exp_q1.push_back(b[i]);
            else            exp_q3.push_back(b[i]);
        end
    endtask

    // One-cycle sample on the 1-counter instance; call at posedge+1.
    task automatic sample1(input logic [9:0] v, input bit accept);
        in_data1[0] = v;
        in_valid1   = 1'b1;
        if (primed1 && accept) push_frame(1, 1, 16'(10'(v - prev1)), 16'd0, 16'd0);
        prev1   = v;
        primed1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
    endtask

    task automatic sample3(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
        in_data3[0] = a;
        in_data3[1] = b;
        in_data3[2] = c;
        in_valid3   = 1'b1;
        if (primed3) push_frame(3, 3, 16'(10'(a - prev3[0])), 16'(10'(b - prev3[1])),
                                16'(10'(c - prev3[2])));
        prev3   = '{a, b, c};
        primed3 = 1'b1;
        @(posedge clk); #1;
        in_valid3 = 1'b0;
    endtask

    task automatic wait_valid1(input string tag);
        for (int i = 0; i < 50; i++) begin
            if (out_valid1) break;
            @(posedge clk); #1;
        end
        check_eq(tag, 32'(out_valid1), 32'd1);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 500; i++) begin
            if (exp_q1.size() == 0 && exp_q3.size() == 0 && !out_valid1 && !out_valid3) break;
            @(posedge clk); #1;
        end
        check_eq({tag, "_q1_left"}, 32'(exp_q1.size()), 32'd0);
        check_eq({tag, "_q3_left"}, 32'(exp_q3.size()), 32'd0);
        check_eq({tag, "_valid_low"}, 32'(out_valid1 | out_valid3), 32'd0);
    endtask

    // Scoreboard monitors: a byte transfers at the next posedge.
    always @(negedge clk) begin
        logic [7:0] e;
        if (rst && out_valid1 && out_ready1) begin
            if (exp_q1.size() == 0) begin
                check_eq("dut1_extra_byte", 32'(out_byte1), 32'hFFFF_FFFF);
            end else begin
                e = exp_q1.pop_front();
                check_eq("dut1_byte", 32'(out_byte1), 32'(e));
            end
        end
    end

    always @(negedge clk) begin
        logic [7:0] e;
        if (rst && out_valid3 && out_ready3) begin
            if (exp_q3.size() == 0) begin
                check_eq("dut3_extra_byte", 32'(out_byte3), 32'hFFFF_FFFF);
            end else begin
                e = exp_q3.pop_front();
                check_eq("dut3_byte", 32'(out_byte3), 32'(e));
            end
        end
    end

    initial begin
        logic [9:0] acc;
        rst        = 1'b0;
        in_valid1  = 1'b0;
        in_valid3  = 1'b0;
        in_data1[0] = 10'd0;
        for (int i = 0; i < 3; i++) in_data3[i] = 10'd0;
        out_ready1 = 1'b1;
        out_ready3 = 1'b1;
        prev1      = 10'd0;
        primed1    = 1'b0;
        prev3      = '{10'd0, 10'd0, 10'd0};
        primed3    = 1'b0;

        // Reset state
        #12;
        check_eq("rst_out_byte", 32'(out_byte1), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid1), 32'd0);
        check_eq("rst_overflow", 32'(overflow1), 32'd0);
        check_eq("rst_fifo_level", 32'(fifo_level1), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // Basic: 100 then 350 -> A5 00 FA; first sample only primes
        sample1(10'd100, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check_eq("prime_no_valid", 32'(out_valid1), 32'd0);
        check_eq("prime_no_level", 32'(fifo_level1), 32'd0);
        sample1(10'd350, 1'b1);
        check_eq("lat1_valid", 32'(out_valid1), 32'd0);
        check_eq("lat1_level", 32'(fifo_level1), 32'd1);
        @(posedge clk); #1;
        check_eq("lat2_valid", 32'(out_valid1), 32'd1);
        wait_drain("basic");

        // Wrap: 1020 then 5 -> d=9
        sample1(10'd1020, 1'b1);
        sample1(10'd5, 1'b1);
        wait_drain("wrap");

        // Backpressure in S_HI
        out_ready1 = 1'b0;
        sample1(10'd7, 1'b1);
        wait_valid1("bp_wait_hdr");
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        out_ready1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_valid_held", 32'(out_valid1), 32'd1);
            check_eq("bp_byte_held", 32'(out_byte1), 32'd0);
        end
        @(posedge clk); #1;
        out_ready1 = 1'b1;
        wait_drain("bp");

        // Three counters: {0,0,0} then {1,512,1023}
        sample3(10'd0, 10'd0, 10'd0);
        sample3(10'd1, 10'd512, 10'd1023);
        wait_drain("ctr3");

        // Overflow: 18 back-to-back deltas with the sink stalled. The first
        // sits in the frame register, the next 16 fill the FIFO, the last drops.
        out_ready1 = 1'b0;
        acc = prev1;
        for (int j = 1; j <= 18; j++) begin
            acc = acc + 10'(j);
            sample1(acc, (j <= 17));
        end
        @(posedge clk); #1;
        check_eq("ovf_level", 32'(fifo_level1), 32'd16);
        check_eq("ovf_flag", 32'(overflow1), 32'd1);
        out_ready1 = 1'b1;
        wait_drain("ovf_drain");
        check_eq("ovf_level_empty", 32'(fifo_level1), 32'd0);
        check_eq("ovf_sticky", 32'(overflow1), 32'd1);

        // Reset mid-frame
        out_ready1 = 1'b0;
        sample1(10'd500, 1'b1);
        sample1(10'd600, 1'b1);
        wait_valid1("rst_wait_hdr");
        check_eq("pre_rst_level", 32'(fifo_level1), 32'd1);
        #3;
        rst = 1'b0;
        #1;
        check_eq("midrst_valid", 32'(out_valid1), 32'd0);
        check_eq("midrst_level", 32'(fifo_level1), 32'd0);
        check_eq("midrst_overflow", 32'(overflow1), 32'd0);
        exp_q1.delete();
        exp_q3.delete();
        prev1   = 10'd0;
        primed1 = 1'b0;
        prev3   = '{10'd0, 10'd0, 10'd0};
        primed3 = 1'b0;
        @(negedge clk);
        rst        = 1'b1;
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        sample1(10'd50, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check_eq("reprime_no_valid", 32'(out_valid1), 32'd0);
        check_eq("reprime_no_level", 32'(fifo_level1), 32'd0);
        sample1(10'd60, 1'b1);
        wait_drain("after_rst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
